// File: rtl/mini_src_datapath.sv
// Mini-SRC single-bus datapath: GPRs, special registers, ALU, CON logic and word RAM.
// All sequencing comes from external control strobes.
module mini_src_datapath #(
   parameter int unsigned MEM_WORDS = 512
) (
   input  logic       Clock,
   input  logic       Clear,
   input  logic       PCin,
   input  logic       IRin,
   input  logic       HIin,
   input  logic       LOin,
   input  logic       ZHighin,
   input  logic       ZLowin,
   input  logic       MARin,
   input  logic       MDRin,
   input  logic       OutPort,
   input  logic       Yin,
   input  logic       PCout,
   input  logic       HIout,
   input  logic       LOout,
   input  logic       ZHighout,
   input  logic       ZLowout,
   input  logic       InPort,
   input  logic       MDRout,
   input  logic       Cout,
   input  logic       Gra,
   input  logic       Grb,
   input  logic       Grc,
   input  logic       Rin,
   input  logic       Rout,
   input  logic       BAout,
   input  logic       Read,
   input  logic       Write,
   input  logic       IncPC,
   input  logic       CON_In,
   input  logic [4:0] OP,
   output logic       CON_Out,
   input  logic       GLR
);
   localparam int unsigned AW = $clog2(MEM_WORDS);

   logic [31:0] regs [0:15];
   logic [31:0] pc_q, ir_q, hi_q, lo_q, y_q, zhi_q, zlo_q, mar_q, mdr_q, outport_q, inport_q;
   logic        con_q;
   logic [31:0] bus, c_sext, ram_rdata;
   logic [63:0] alu_res, prod;
   logic [3:0]  sel;
   logic [4:0]  sh;
   logic signed [31:0] sa, sb;
   logic [AW-1:0] ram_addr;
   logic        cond;

   assign c_sext   = {{13{ir_q[18]}}, ir_q[18:0]};
   assign sel      = GLR ? 4'd15 : (({4{Gra}} & ir_q[26:23]) | ({4{Grb}} & ir_q[22:19]) |
                                    ({4{Grc}} & ir_q[18:15]));
   assign ram_addr = mar_q[AW-1:0];
   assign CON_Out  = con_q;

   always_comb begin
      bus = '0;
      if (Rout)          bus = regs[sel];
      else if (BAout)    bus = (sel == 4'd0) ? '0 : regs[sel];
      else if (HIout)    bus = hi_q;
      else if (LOout)    bus = lo_q;
      else if (ZHighout) bus = zhi_q;
      else if (ZLowout)  bus = zlo_q;
      else if (PCout)    bus = pc_q;
      else if (MDRout)   bus = mdr_q;
      else if (InPort)   bus = inport_q;
      else if (Cout)     bus = c_sext;
   end

   assign sh   = bus[4:0];
   assign sa   = y_q;
   assign sb   = bus;
   // Low 64 bits of the product of sign-extended operands equal the signed product.
   assign prod = {{32{y_q[31]}}, y_q} * {{32{bus[31]}}, bus};

   always_comb begin
      alu_res = {32'd0, bus};
      case (OP)
         5'b00100: alu_res = {32'd0, y_q + bus};
         5'b00101: alu_res = {32'd0, y_q - bus};
         5'b00110: alu_res = {32'd0, y_q >> sh};
         5'b00111: alu_res = {32'd0, sa >>> sh};
         5'b01000: alu_res = {32'd0, y_q << sh};
         5'b01001: alu_res = {32'd0, (y_q >> sh) | (y_q << (6'd32 - {1'b0, sh}))};
         5'b01010: alu_res = {32'd0, (y_q << sh) | (y_q >> (6'd32 - {1'b0, sh}))};
         5'b01011: alu_res = {32'd0, y_q & bus};
         5'b01100: alu_res = {32'd0, y_q | bus};
         5'b01101: alu_res = prod;
         5'b01110: alu_res = (bus == 32'd0) ? 64'd0 : {sa % sb, sa / sb};
         5'b01111: alu_res = {32'd0, 32'd0 - bus};
         5'b10000: alu_res = {32'd0, ~bus};
         default:  ;
      endcase
   end

   always_comb begin
      cond = 1'b0;
      case (ir_q[20:19])
         2'b00: cond = (bus == 32'd0);
         2'b01: cond = (bus != 32'd0);
         2'b10: cond = ~bus[31];
         2'b11: cond = bus[31];
         default: ;
      endcase
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         pc_q      <= '0;
         ir_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         y_q       <= '0;
         zhi_q     <= '0;
         zlo_q     <= '0;
         mar_q     <= '0;
         mdr_q     <= '0;
         outport_q <= '0;
         inport_q  <= '0;
         con_q     <= 1'b0;
      end else begin
         if (PCin)         pc_q <= bus;
         else if (IncPC)   pc_q <= pc_q + 32'd1;
         if (IRin)         ir_q      <= bus;
         if (HIin)         hi_q      <= bus;
         if (LOin)         lo_q      <= bus;
         if (Yin)          y_q       <= bus;
         if (ZHighin)      zhi_q     <= alu_res[63:32];
         if (ZLowin)       zlo_q     <= alu_res[31:0];
         if (MARin)        mar_q     <= bus;
         if (MDRin)        mdr_q     <= Read ? ram_rdata : bus;
         if (OutPort)      outport_q <= bus;
         if (CON_In)       con_q     <= cond;
      end
   end

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         for (int i = 0; i < 16; i++) regs[i] <= '0;
      end else if (Rin) begin
         regs[sel] <= bus;
      end
   end

   // RAM contents survive Clear; reads are combinational.
   if (1) begin : ram_instance
      logic [31:0] memory [0:MEM_WORDS-1];
      always_ff @(posedge Clock) begin
         if (Write) memory[ram_addr] <= mdr_q;
      end
      assign ram_rdata = memory[ram_addr];
   end

   logic unused_bits;
   assign unused_bits = ^{ir_q[31:27], outport_q, mar_q[31:AW]};

endmodule

// File: tb/tb_mini_src_datapath.sv
// Scoreboard bench for mini_src_datapath: directed instruction flows plus randomized ALU,
// CON and register traffic checked against an instruction-level reference model.
module tb_mini_src_datapath;
   logic Clock = 1'b0;
   logic Clear;
   logic PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
   logic PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR;
   logic [4:0] OP;
   logic CON_Out;

   always #5 Clock = ~Clock;

   mini_src_datapath #(.MEM_WORDS(512)) dut (
      .Clock(Clock), .Clear(Clear), .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin),
      .ZHighin(ZHighin), .ZLowin(ZLowin), .MARin(MARin), .MDRin(MDRin), .OutPort(OutPort),
      .Yin(Yin), .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout),
      .ZLowout(ZLowout), .InPort(InPort), .MDRout(MDRout), .Cout(Cout), .Gra(Gra), .Grb(Grb),
      .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Read(Read), .Write(Write),
      .IncPC(IncPC), .CON_In(CON_In), .OP(OP), .CON_Out(CON_Out), .GLR(GLR)
   );

   localparam int KPc = 0, KIr = 1, KY = 2, KZhi = 3, KZlo = 4, KMar = 5, KMdr = 6, KHi = 7;
   localparam int KLo = 8, KReg = 9, KCon = 10, KMem = 11, KOut = 12;

   typedef struct {
      int          kind;
      int          idx;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state
   logic [31:0] m_pc, m_ir, m_y, m_zhi, m_zlo, m_mar, m_mdr, m_hi, m_lo, m_out;
   logic [31:0] m_reg [16];
   logic [31:0] mmem [512];
   logic        m_con;

   logic [31:0] ra_v, rb_v;
   logic [4:0]  op_r;
   int          kind_sel;

   function automatic logic [31:0] actual(input int kind, input int idx);
      case (kind)
         KPc:     return dut.pc_q;
         KIr:     return dut.ir_q;
         KY:      return dut.y_q;
         KZhi:    return dut.zhi_q;
         KZlo:    return dut.zlo_q;
         KMar:    return dut.mar_q;
         KMdr:    return dut.mdr_q;
         KHi:     return dut.hi_q;
         KLo:     return dut.lo_q;
         KReg:    return dut.regs[idx];
         KCon:    return {31'd0, CON_Out};
         KMem:    return dut.ram_instance.memory[idx];
         KOut:    return dut.outport_q;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   always @(negedge Clock) begin : monitor
      exp_t        e;
      logic [31:0] act;
      while (sb_q.size() > 0) begin
         e   = sb_q.pop_front();
         act = actual(e.kind, e.idx);
         n_checks++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", e.name, act, e.val, $time);
         end
      end
   end

   task automatic push_exp(input int kind, input int idx, input logic [31:0] v, input string nm);
      sb_q.push_back('{kind, idx, v, nm});
   endtask

   function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      int          n, sa, sb;
      logic [31:0] r;
      longint      p;
      n  = int'(b % 32);
      r  = a;
      sa = a;
      sb = b;
      case (op)
         5'd4:  return {32'd0, a + b};
         5'd5:  return {32'd0, a - b};
         5'd6: begin
            for (int i = 0; i < n; i++) r = r / 2;
            return {32'd0, r};
         end
         5'd7: begin
            for (int i = 0; i < n; i++) sa = (sa < 0 && sa % 2 != 0) ? sa / 2 - 1 : sa / 2;
            return {32'd0, sa};
         end
         5'd8: begin
            for (int i = 0; i < n; i++) r = r * 2;
            return {32'd0, r};
         end
         5'd9: begin
            for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
            return {32'd0, r};
         end
         5'd10: begin
            for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
            return {32'd0, r};
         end
         5'd11: return {32'd0, a & b};
         5'd12: return {32'd0, a | b};
         5'd13: begin
            p = longint'(sa) * longint'(sb);
            return p;
         end
         5'd14: return (b == 32'd0) ? 64'd0 : {sa % sb, sa / sb};
         5'd15: return {32'd0, 32'd0 - b};
         5'd16: return {32'd0, ~b};
         default: return {32'd0, b};
      endcase
   endfunction

   function automatic logic ref_cond(input logic [1:0] c2, input logic [31:0] v);
      case (c2)
         2'd0:    return v == 32'd0;
         2'd1:    return v != 32'd0;
         2'd2:    return v < 32'h8000_0000;
         default: return v >= 32'h8000_0000;
      endcase
   endfunction

   task automatic clr();
      {PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin} = '0;
      {PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout} = '0;
      {Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In, GLR} = '0;
      OP = '0;
   endtask

   task automatic go();
      @(posedge Clock);
      #1;
      clr();
   endtask

   task automatic model_reset();
      {m_pc, m_ir, m_y, m_zhi, m_zlo, m_mar, m_mdr, m_hi, m_lo, m_out} = '0;
      m_con = 1'b0;
      for (int i = 0; i < 16; i++) m_reg[i] = '0;
   endtask

   task automatic push_reset_checks();
      push_exp(KPc, 0, m_pc, "rst_pc");
      push_exp(KIr, 0, m_ir, "rst_ir");
      push_exp(KY, 0, m_y, "rst_y");
      push_exp(KZhi, 0, m_zhi, "rst_zhi");
      push_exp(KZlo, 0, m_zlo, "rst_zlo");
      push_exp(KMar, 0, m_mar, "rst_mar");
      push_exp(KMdr, 0, m_mdr, "rst_mdr");
      push_exp(KHi, 0, m_hi, "rst_hi");
      push_exp(KOut, 0, m_out, "rst_out");
      push_exp(KCon, 0, {31'd0, m_con}, "rst_con");
      push_exp(KReg, 1, m_reg[1], "rst_r1");
      push_exp(KReg, 15, m_reg[15], "rst_r15");
   endtask

   task automatic do_reset();
      Clear = 1'b0;
      clr();
      model_reset();
      push_reset_checks();
      @(negedge Clock);
      #1;
      Clear = 1'b1;
      @(posedge Clock);
      #1;
   endtask

   task automatic write_mem(input int addr, input logic [31:0] v);
      mmem[addr] = v;
      dut.ram_instance.memory[addr] = v;
   endtask

   task automatic load_mdr(input logic [31:0] v);
      write_mem(int'(m_mar[8:0]), v);
      Read = 1; MDRin = 1; go();
      m_mdr = v;
   endtask

   // ld Ra, C(Rb) fetched from memory[PC]
   task automatic do_ld(input string nm);
      logic [3:0]  ra, rb;
      logic [31:0] base, ea;
      PCout = 1; MARin = 1; go();
      Read = 1; MDRin = 1; IncPC = 1; go();
      MDRout = 1; IRin = 1; go();
      Grb = 1; BAout = 1; Yin = 1; go();
      Cout = 1; OP = 5'b00100; ZLowin = 1; go();
      ZLowout = 1; MARin = 1; go();
      Read = 1; MDRin = 1; go();
      MDRout = 1; Gra = 1; Rin = 1; go();
      m_ir  = mmem[int'(m_pc[8:0])];
      m_pc  = m_pc + 1;
      ra    = m_ir[26:23];
      rb    = m_ir[22:19];
      base  = (rb == 0) ? 32'd0 : m_reg[rb];
      ea    = base + 32'($signed(m_ir[18:0]));
      m_y   = base;
      m_zlo = ea;
      m_mar = ea;
      m_mdr = mmem[int'(ea[8:0])];
      m_reg[ra] = m_mdr;
      push_exp(KPc, 0, m_pc, {nm, "_pc"});
      push_exp(KIr, 0, m_ir, {nm, "_ir"});
      push_exp(KY, 0, m_y, {nm, "_y"});
      push_exp(KZlo, 0, m_zlo, {nm, "_zlo"});
      push_exp(KMar, 0, m_mar, {nm, "_mar"});
      push_exp(KReg, int'(ra), m_reg[ra], {nm, "_ra"});
   endtask

   task automatic alu_t(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      logic [63:0] r;
      load_mdr(a);
      MDRout = 1; Yin = 1; go();
      m_y = a;
      load_mdr(b);
      MDRout = 1; OP = op; ZHighin = 1; ZLowin = 1; go();
      r = ref_alu(op, a, b);
      {m_zhi, m_zlo} = r;
      push_exp(KY, 0, m_y, "alu_y");
      push_exp(KZhi, 0, m_zhi, $sformatf("alu_zhi_op%0d", op));
      push_exp(KZlo, 0, m_zlo, $sformatf("alu_zlo_op%0d", op));
      ZHighout = 1; HIin = 1; go();
      m_hi = m_zhi;
      push_exp(KHi, 0, m_hi, "alu_hi");
      ZLowout = 1; LOin = 1; go();
      m_lo = m_zlo;
      push_exp(KLo, 0, m_lo, "alu_lo");
   endtask

   task automatic con_t(input logic [31:0] ir, input logic [31:0] v);
      load_mdr(ir);
      MDRout = 1; IRin = 1; go();
      m_ir = ir;
      load_mdr(v);
      MDRout = 1; CON_In = 1; go();
      m_con = ref_cond(m_ir[20:19], v);
      push_exp(KCon, 0, {31'd0, m_con}, $sformatf("con_c2_%0d", m_ir[20:19]));
   endtask

   task automatic reg_rw(input logic [31:0] v);
      logic [3:0] ra;
      ra = m_ir[26:23];
      load_mdr(v);
      MDRout = 1; Gra = 1; Rin = 1; go();
      m_reg[ra] = v;
      Gra = 1; BAout = 1; Yin = 1; go();
      m_y = (ra == 0) ? 32'd0 : m_reg[ra];
      push_exp(KY, 0, m_y, "baout_y");
      Gra = 1; Rout = 1; Yin = 1; go();
      m_y = m_reg[ra];
      push_exp(KY, 0, m_y, "rout_y");
      push_exp(KReg, int'(ra), m_reg[ra], "gpr_write");
      MDRout = 1; GLR = 1; Gra = 1; Rin = 1; go();
      m_reg[15] = v;
      push_exp(KReg, 15, m_reg[15], "glr_r15");
      MDRout = 1; PCin = 1; IncPC = 1; go();
      m_pc = v;
      push_exp(KPc, 0, m_pc, "pcin_wins");
      MDRout = 1; OutPort = 1; go();
      m_out = v;
      push_exp(KOut, 0, m_out, "outport");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clr();
      for (int i = 0; i < 512; i++) mmem[i] = '0;
      do_reset();

      // ld R1,$75 then ld R0,$45(R1)
      write_mem(0, 32'h0080_0075);
      write_mem(117, 32'd4);
      write_mem(1, 32'h0008_0045);
      write_mem(73, 32'd8);
      do_ld("ld1");
      push_exp(KReg, 1, 32'd4, "ld1_r1_is_4");
      push_exp(KPc, 0, 32'd1, "ld1_pc_is_1");
      do_ld("ld2");
      push_exp(KMar, 0, 32'h49, "ld2_mar_is_49");
      push_exp(KReg, 0, 32'd8, "ld2_r0_is_8");

      // R0 = 0xFFFF: BAout gives 0, Rout gives the value
      reg_rw(32'h0000_FFFF);

      alu_t(32'hFFFF_FFFE, 32'd3, 5'b01101);
      push_exp(KZhi, 0, 32'hFFFF_FFFF, "mul_zhi_const");
      push_exp(KZlo, 0, 32'hFFFF_FFFA, "mul_zlo_const");
      alu_t(32'd7, 32'd2, 5'b01110);
      push_exp(KZlo, 0, 32'd3, "div_quot_const");
      push_exp(KZhi, 0, 32'd1, "div_rem_const");
      alu_t(32'd9, 32'd0, 5'b01110);
      push_exp(KZlo, 0, 32'd0, "div0_zlo_const");

      con_t(32'h0008_0000, 32'd5);
      push_exp(KCon, 0, 32'd1, "con_ne_const");
      con_t(32'h0000_0000, 32'd5);
      push_exp(KCon, 0, 32'd0, "con_eq_const");

      // Reset in the middle of an active cycle
      do_reset();
      load_mdr(32'h0080_0000);
      MDRout = 1; IRin = 1; go();
      m_ir = 32'h0080_0000;
      load_mdr(32'd4);
      MDRout = 1; Gra = 1; Rin = 1; go();
      m_reg[1] = 32'd4;
      for (int i = 0; i < 3; i++) begin
         IncPC = 1; go();
         m_pc = m_pc + 1;
      end
      push_exp(KPc, 0, 32'd3, "pre_rst_pc");
      push_exp(KReg, 1, 32'd4, "pre_rst_r1");
      IncPC = 1; Read = 1; MDRin = 1;
      @(posedge Clock);
      #2;
      Clear = 1'b0;
      clr();
      model_reset();
      push_reset_checks();
      push_exp(KMem, 0, mmem[0], "ram_kept");
      @(negedge Clock);
      #1;
      Clear = 1'b1;
      @(posedge Clock);
      #1;

      // Randomized traffic; MAR stays 0 throughout
      for (int it = 0; it < 60; it++) begin
         kind_sel = $urandom_range(0, 3);
         ra_v = $urandom;
         rb_v = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if (kind_sel <= 1) begin
            op_r = ($urandom_range(0, 3) != 0) ? 5'(4 + $urandom_range(0, 12))
                                                : 5'($urandom_range(0, 31));
            if (op_r == 5'b01110 && rb_v == 32'hFFFF_FFFF) rb_v = 32'd3;
            alu_t(ra_v, rb_v, op_r);
         end else if (kind_sel == 2) begin
            con_t($urandom, ($urandom_range(0, 3) == 0) ? 32'd0 : rb_v);
         end else begin
            reg_rw(ra_v);
         end
      end

      @(negedge Clock);
      #1;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
